// File: rtl/coeff_token_scan_pkg.sv
// Shared CAVLC definitions: FSM state type, block-length constants and the
// field widths of the coeff_token lookup address {T1s, NZQs}.
package cavlcPkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int unsigned BLK_LEN_FULL = 16;
  localparam int unsigned BLK_LEN_AC   = 15;

  localparam logic [3:0] LAST_IDX_FULL = 4'(BLK_LEN_FULL - 1);
  localparam logic [3:0] LAST_IDX_AC   = 4'(BLK_LEN_AC - 1);

  localparam int unsigned T1_W   = 2;
  localparam int unsigned TC_W   = 5;
  localparam int unsigned ADDR_W = T1_W + TC_W;

endpackage

// File: rtl/coeff_token_scan_classify.sv
// coeffClassify: purely combinational classification of one signed
// coefficient. isOne matches exactly +1 or -1 (no abs), so the most
// negative value is never mistaken for a one.
module coeffClassify #(
  parameter int cWIDTH = 16
) (
  input  logic [cWIDTH-1:0] coeffIn,
  output logic              isNonZero,
  output logic              isOne,
  output logic              sign
);

  localparam logic [cWIDTH-1:0] POS_ONE = cWIDTH'(1);
  localparam logic [cWIDTH-1:0] NEG_ONE = '1;

  // Classify the coefficient by exact bit-pattern comparison.
  always_comb begin
    isNonZero = (coeffIn != '0);
    isOne     = (coeffIn == POS_ONE) || (coeffIn == NEG_ONE);
    sign      = coeffIn[cWIDTH-1];
  end

endmodule

// File: rtl/coeff_token_scan.sv
// coeff_token_scan: accumulates one zig-zag-ordered block of quantised
// coefficients and produces the CAVLC coeff_token address, trailing-one
// signs and total_zeros. Optional macro CAVLC_AC_BLOCK_EN adds input
// isAcBlk selecting a 15-coefficient block.
module coeff_token_scan
  import cavlcPkg::*;
#(
  parameter int cWIDTH = 16,
  parameter int aWIDTH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CAVLC_AC_BLOCK_EN
  input  logic              isAcBlk,
`endif
  input  logic [cWIDTH-1:0] coeffIn,
  input  logic              inValid,
  output logic              inReady,
  output logic [aWIDTH-1:0] coeffTokenAddr,
  output logic [2:0]        t1Signs,
  output logic [3:0]        totalZeros,
  output logic              outValid,
  input  logic              outReady
);

  state_t            r_state;
  logic [3:0]        r_idx;
  logic [TC_W-1:0]   r_tc;
  logic [T1_W-1:0]   r_t1;
  logic [2:0]        r_signs;
  logic [3:0]        r_lastNz;

  logic [aWIDTH-1:0] r_addr;
  logic [2:0]        r_t1Signs;
  logic [3:0]        r_tz;
  logic              r_outValid;

  logic              w_nz;
  logic              w_one;
  logic              w_sign;
  logic              w_accept;
  logic              w_last;
  logic [3:0]        w_lastIdx;
  logic [TC_W-1:0]   w_tc_nxt;
  logic [T1_W-1:0]   w_t1_nxt;
  logic [2:0]        w_signs_nxt;
  logic [3:0]        w_lastNz_nxt;
  logic [4:0]        w_tzFull;

  coeffClassify #(.cWIDTH(cWIDTH)) u_classify (
    .coeffIn   (coeffIn),
    .isNonZero (w_nz),
    .isOne     (w_one),
    .sign      (w_sign)
  );

`ifdef CAVLC_AC_BLOCK_EN
  logic r_isAc;
  logic w_isAc;

  // isAcBlk is taken live with index 0, and from the register afterwards.
  always_comb begin
    w_isAc    = (r_state == ST_IDLE) ? isAcBlk : r_isAc;
    w_lastIdx = w_isAc ? LAST_IDX_AC : LAST_IDX_FULL;
  end

  // Hold the block type for the remainder of the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_isAc <= 1'b0;
    else if (w_accept && (r_state == ST_IDLE))    r_isAc <= isAcBlk;
  end
`else
  assign w_lastIdx = LAST_IDX_FULL;
`endif

  assign inReady  = (r_state != ST_DONE);
  assign w_accept = inValid && inReady;
  assign w_last   = w_accept && (r_idx == w_lastIdx);

  // Accumulator values after absorbing the current coefficient.
  always_comb begin
    w_tc_nxt     = r_tc;
    w_t1_nxt     = r_t1;
    w_signs_nxt  = r_signs;
    w_lastNz_nxt = r_lastNz;
    if (w_nz) begin
      w_tc_nxt     = r_tc + TC_W'(1);
      w_lastNz_nxt = r_idx;
      if (w_one) begin
        w_t1_nxt    = (r_t1 == 2'd3) ? 2'd3 : r_t1 + 2'd1;
        w_signs_nxt = {r_signs[1:0], w_sign};
      end else begin
        w_t1_nxt    = '0;
        w_signs_nxt = '0;
      end
    end
    w_tzFull = (w_tc_nxt == '0) ? '0
             : ({1'b0, w_lastNz_nxt} + 5'd1 - w_tc_nxt);
  end

  // Block FSM and per-block accumulators; accumulators clear on leaving DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_tc     <= '0;
      r_t1     <= '0;
      r_signs  <= '0;
      r_lastNz <= '0;
    end else begin
      if (w_accept) begin
        r_idx    <= r_idx + 4'd1;
        r_tc     <= w_tc_nxt;
        r_t1     <= w_t1_nxt;
        r_signs  <= w_signs_nxt;
        r_lastNz <= w_lastNz_nxt;
      end
      case (r_state)
        ST_IDLE: if (w_accept) r_state <= ST_SCAN;
        ST_SCAN: if (w_last)   r_state <= ST_DONE;
        ST_DONE: begin
          if (r_outValid && outReady) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_tc     <= '0;
            r_t1     <= '0;
            r_signs  <= '0;
            r_lastNz <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result registers: captured with the last coefficient, held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_t1Signs  <= '0;
      r_tz       <= '0;
      r_outValid <= 1'b0;
    end else if (w_last) begin
      r_addr     <= aWIDTH'({w_t1_nxt, w_tc_nxt});
      r_t1Signs  <= w_signs_nxt;
      r_tz       <= w_tzFull[3:0];
      r_outValid <= 1'b1;
    end else if (r_outValid && outReady) begin
      r_outValid <= 1'b0;
    end
  end

  assign coeffTokenAddr = r_addr;
  assign t1Signs        = r_t1Signs;
  assign totalZeros     = r_tz;
  assign outValid       = r_outValid;

endmodule

// File: tb/tb_coeff_token_scan.sv
// Self-checking bench for coeff_token_scan: directed blocks plus random
// blocks compared against a reference model that derives the CAVLC fields
// directly from the block contents.
module tb_coeff_token_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] coeffIn;
  logic        inValid;
  logic        inReady;
  logic [6:0]  coeffTokenAddr;
  logic [2:0]  t1Signs;
  logic [3:0]  totalZeros;
  logic        outValid;
  logic        outReady;
`ifdef CAVLC_AC_BLOCK_EN
  logic        isAcBlk;
`endif

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] blk [16];
  bit                 cur_ac;
  logic [6:0]         exp_addr;
  logic [2:0]         exp_signs;
  logic [3:0]         exp_tz;

  always #5 clk = ~clk;

  coeff_token_scan #(.cWIDTH(16), .aWIDTH(7)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef CAVLC_AC_BLOCK_EN
    .isAcBlk        (isAcBlk),
`endif
    .coeffIn        (coeffIn),
    .inValid        (inValid),
    .inReady        (inReady),
    .coeffTokenAddr (coeffTokenAddr),
    .t1Signs        (t1Signs),
    .totalZeros     (totalZeros),
    .outValid       (outValid),
    .outReady       (outReady)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: total coeffs = nonzero count; trailing ones = +-1 values at
  // the high-index end of the nonzero list (max 3, nearest-to-end at bit0).
  function automatic void model(input int n);
    int tc = 0;
    int last = -1;
    int t1 = 0;
    bit stop = 0;
    logic [2:0] sg = '0;
    for (int i = 0; i < n; i++)
      if (blk[i] != 0) begin tc++; last = i; end
    for (int i = n - 1; i >= 0 && !stop; i--) begin
      if (blk[i] != 0) begin
        if (blk[i] == 1 || blk[i] == -1) begin
          if (t1 < 3) begin sg[t1] = (blk[i] < 0); t1++; end
        end else stop = 1;
      end
    end
    exp_addr  = {2'(t1), 5'(tc)};
    exp_signs = sg;
    exp_tz    = (tc == 0) ? 4'd0 : 4'(last + 1 - tc);
  endfunction

  function automatic logic signed [15:0] rnd_coef();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 16'sd0;
      4, 5:       return 16'sd1;
      6:          return -16'sd1;
      7:          return 16'sh8000;
      8:          return 16'($urandom_range(2, 5));
      default:    return 16'($urandom);
    endcase
  endfunction

  function automatic int blk_len();
    return cur_ac ? 15 : 16;
  endfunction

  // Feed one block (starting just after a rising edge); optional idle gaps.
  task automatic send_block(input bit gaps);
    int n = blk_len();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        inValid = 1'b0;
        coeffIn = 16'($urandom);
        @(posedge clk); #1;
      end
      coeffIn = blk[i];
      inValid = 1'b1;
`ifdef CAVLC_AC_BLOCK_EN
      isAcBlk = cur_ac;
`endif
      chk("in_ready", 32'(inReady), 32'd1);
      if (i == n - 1) chk("valid_before_last", 32'(outValid), 32'd0);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    coeffIn = '0;
  endtask

  task automatic check_result(input string tag);
    model(blk_len());
    chk({tag, "_valid"}, 32'(outValid), 32'd1);
    chk({tag, "_addr"},  32'(coeffTokenAddr), 32'(exp_addr));
    chk({tag, "_signs"}, 32'(t1Signs), 32'(exp_signs));
    chk({tag, "_tz"},    32'(totalZeros), 32'(exp_tz));
  endtask

  task automatic drain(input int wait_cycles);
    for (int k = 0; k < wait_cycles; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(outValid), 32'd1);
      chk("hold_ready", 32'(inReady), 32'd0);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    chk("drain_valid", 32'(outValid), 32'd0);
    chk("drain_ready", 32'(inReady), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0; coeffIn = '0; cur_ac = 0;
`ifdef CAVLC_AC_BLOCK_EN
    isAcBlk = 1'b0;
`endif
    #12;
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_addr",  32'(coeffTokenAddr), 32'd0);
    chk("rst_signs", 32'(t1Signs), 32'd0);
    chk("rst_tz",    32'(totalZeros), 32'd0);
    chk("rst_ready", 32'(inReady), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 0,3,-1,0,1 then zeros
    foreach (blk[i]) blk[i] = 16'sd0;
    blk[1] = 16'sd3; blk[2] = -16'sd1; blk[4] = 16'sd1;
    send_block(0); check_result("mixed"); drain(0);

    // 5 then 1,1,-1,1: trailing ones saturate at 3
    foreach (blk[i]) blk[i] = 16'sd0;
    blk[0] = 16'sd5; blk[1] = 16'sd1; blk[2] = 16'sd1; blk[3] = -16'sd1; blk[4] = 16'sd1;
    send_block(0); check_result("sat"); drain(0);

    // all-zero block
    foreach (blk[i]) blk[i] = 16'sd0;
    send_block(0); check_result("zero"); drain(0);

    // sixteen +-1
    foreach (blk[i]) blk[i] = ($urandom_range(0, 1) == 1) ? 16'sd1 : -16'sd1;
    send_block(0); check_result("ones"); drain(0);

    // most negative value is not a one
    foreach (blk[i]) blk[i] = 16'sd0;
    blk[0] = 16'sd1; blk[3] = -16'sd1; blk[10] = 16'sh8000;
    send_block(0); check_result("minneg"); drain(0);

    // hold for 5 cycles, then back-to-back next block
    foreach (blk[i]) blk[i] = rnd_coef();
    send_block(0); check_result("hold0");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_addr",  32'(coeffTokenAddr), 32'(exp_addr));
      chk("hold_signs", 32'(t1Signs), 32'(exp_signs));
      chk("hold_tz",    32'(totalZeros), 32'(exp_tz));
      chk("hold_ready", 32'(inReady), 32'd0);
    end
    drain(0);
    foreach (blk[i]) blk[i] = rnd_coef();
    send_block(0); check_result("b2b"); drain(0);

    // reset after index 7 discards the partial block
    foreach (blk[i]) blk[i] = 16'sd1;
    for (int i = 0; i < 8; i++) begin
      coeffIn = blk[i]; inValid = 1'b1;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    rst_n = 1'b0; #1;
    chk("midrst_valid", 32'(outValid), 32'd0);
    chk("midrst_ready", 32'(inReady), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (blk[i]) blk[i] = rnd_coef();
    send_block(0); check_result("postrst");

    // reset while a result is pending drops outValid at once
    rst_n = 1'b0; #1;
    chk("donerst_valid", 32'(outValid), 32'd0);
    chk("donerst_addr",  32'(coeffTokenAddr), 32'd0);
    chk("donerst_ready", 32'(inReady), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef CAVLC_AC_BLOCK_EN
    // AC block of fifteen ones
    cur_ac = 1;
    foreach (blk[i]) blk[i] = 16'sd1;
    send_block(0); check_result("ac_ones"); drain(0);
    cur_ac = 0;
`endif

    // random blocks with input gaps and random result back-pressure
    for (int b = 0; b < 40; b++) begin
`ifdef CAVLC_AC_BLOCK_EN
      cur_ac = ($urandom_range(0, 1) == 1);
`endif
      foreach (blk[i]) blk[i] = rnd_coef();
      send_block(1);
      check_result("rand");
      drain($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
